// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among N_REQ
// writeback sources, with a registered output stage driving the file directly.
module rf_write_arbiter #(
  parameter  int WIDTH  = 32,
  parameter  int ADDR_W = 5,
  parameter  int N_REQ  = 2,
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*WIDTH-1:0]    req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [ADDR_W-1:0]         write_addr,
  output logic [WIDTH-1:0]          write_data,
  output logic                      rf_en,
  output logic [IDX_W-1:0]          last_grant,
  output logic                      conflict
);

  logic [N_REQ-1:0][ADDR_W-1:0] addr_v;
  logic [N_REQ-1:0][WIDTH-1:0]  data_v;
  logic [IDX_W-1:0]             ptr;
  logic [IDX_W-1:0]             gnt_idx;
  logic [IDX_W-1:0]             cand;
  logic [IDX_W-1:0]             ptr_nxt;
  logic                         gnt_any;
  logic                         accept;
  logic                         multi_vld;
  int                           off;

  assign addr_v = req_addr;
  assign data_v = req_data;

  // Scan from the highest rotation offset down so the nearest valid index
  // at or after the pointer is the one left standing.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    off     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      off  = (int'(ptr) + k) % N_REQ;
      cand = IDX_W'(off);
      if (req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Grant never looks at addr/data, so a write to x0 is still consumed.
  assign accept    = gnt_any & ~stall & ~rst;
  assign multi_vld = |(req_valid & (req_valid - 1'b1));
  assign ptr_nxt   = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      last_grant <= '0;
      rf_en      <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      conflict   <= 1'b0;
    end else begin
      conflict <= multi_vld & ~stall;
      if (accept) begin
        ptr        <= ptr_nxt;
        last_grant <= gnt_idx;
        write_addr <= addr_v[gnt_idx];
        write_data <= data_v[gnt_idx];
        rf_en      <= |addr_v[gnt_idx];
      end else begin
        rf_en      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: scenario tasks plus a negedge scoreboard that
// models the round-robin grant and queues expected register-file writes.
module tb_rf_write_arbiter;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int N_REQ  = 2;
  localparam int IDX_W  = $clog2(N_REQ);

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
    logic              en;
  } wr_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    stall = 1'b0;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr = '0;
  logic [N_REQ*WIDTH-1:0]  req_data = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]       write_addr;
  logic [WIDTH-1:0]        write_data;
  logic                    rf_en;
  logic [IDX_W-1:0]        last_grant;
  logic                    conflict;

  int  n_tests = 0;
  int  n_fail  = 0;
  wr_t sbq[$];

  rf_write_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .N_REQ(N_REQ)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .write_addr(write_addr), .write_data(write_data),
    .rf_en(rf_en), .last_grant(last_grant), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a,
                         input logic [WIDTH-1:0] d);
    req_valid[i]                 = v;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*WIDTH +: WIDTH]   = d;
  endtask

  // Independent model: checks every negedge, then predicts the next edge.
  task automatic scoreboard();
    int                mptr;
    int                g;
    logic [IDX_W-1:0]  mlg;
    logic              mconf;
    logic              pend;
    logic [ADDR_W-1:0] h_addr;
    logic [WIDTH-1:0]  h_data;
    logic [N_REQ-1:0]  e_rdy;
    wr_t               e;
    mptr = 0; mlg = '0; mconf = 1'b0; pend = 1'b0; h_addr = '0; h_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_tests++;
        if (req_ready !== '0 || rf_en !== 1'b0 || write_addr !== '0 || write_data !== '0 ||
            conflict !== 1'b0 || last_grant !== '0) begin
          n_fail++;
          $display("FAIL sb_reset: ready=%b rf_en=%b addr=%0d data=%h conflict=%b lg=%0d, required all 0",
                   req_ready, rf_en, write_addr, write_data, conflict, last_grant);
        end
        sbq.delete();
        mptr = 0; mlg = '0; mconf = 1'b0; pend = 1'b0; h_addr = '0; h_data = '0;
        continue;
      end
      g = -1;
      if (!stall)
        for (int k = 0; k < N_REQ; k++)
          if (g < 0 && req_valid[(mptr + k) % N_REQ]) g = (mptr + k) % N_REQ;
      e_rdy = '0;
      if (g >= 0) e_rdy[g] = 1'b1;
      n_tests++;
      if (req_ready !== e_rdy) begin
        n_fail++;
        $display("FAIL sb_ready: got %b, required %b", req_ready, e_rdy);
      end
      if (pend) begin
        e = sbq.pop_front();
        h_addr = e.addr;
        h_data = e.data;
        n_tests++;
        if (rf_en !== e.en || write_addr !== e.addr || write_data !== e.data) begin
          n_fail++;
          $display("FAIL sb_write: got en=%b addr=%0d data=%h, required en=%b addr=%0d data=%h",
                   rf_en, write_addr, write_data, e.en, e.addr, e.data);
        end
      end else begin
        n_tests++;
        if (rf_en !== 1'b0 || write_addr !== h_addr || write_data !== h_data) begin
          n_fail++;
          $display("FAIL sb_idle: got en=%b addr=%0d data=%h, required en=0 addr=%0d data=%h",
                   rf_en, write_addr, write_data, h_addr, h_data);
        end
      end
      n_tests++;
      if (conflict !== mconf || last_grant !== mlg) begin
        n_fail++;
        $display("FAIL sb_status: got conflict=%b lg=%0d, required conflict=%b lg=%0d",
                 conflict, last_grant, mconf, mlg);
      end
      mconf = ($countones(req_valid) > 1) && !stall;
      pend  = (g >= 0);
      if (pend) begin
        e.addr = req_addr[g*ADDR_W +: ADDR_W];
        e.data = req_data[g*WIDTH +: WIDTH];
        e.en   = (e.addr != '0);
        sbq.push_back(e);
        mptr = (g + 1) % N_REQ;
        mlg  = IDX_W'(g);
      end
    end
  endtask

  task automatic test_reset();
    set_req(0, 1'b1, 5'd9, 32'h1111_1111);
    #1;
    n_tests++;
    if (req_ready !== '0 || rf_en !== 1'b0 || last_grant !== '0 || conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b rf_en=%b lg=%0d conflict=%b, required 0",
               req_ready, rf_en, last_grant, conflict);
    end
    tick();
    set_req(0, 1'b0, '0, '0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL single_ready: got %b, required 01", req_ready);
    end
    tick();
    set_req(0, 1'b0, '0, '0);
    n_tests++;
    if (rf_en !== 1'b1 || write_addr !== 5'd5 || write_data !== 32'hDEAD_BEEF || last_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL single_write: en=%b addr=%0d data=%h lg=%0d, required 1/5/deadbeef/0",
               rf_en, write_addr, write_data, last_grant);
    end
  endtask

  task automatic test_x0_write();
    set_req(1, 1'b1, 5'd0, 32'h0000_1234);
    #1;
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL x0_ready: got %b, required 10", req_ready);
    end
    tick();
    set_req(1, 1'b0, '0, '0);
    n_tests++;
    if (rf_en !== 1'b0 || last_grant !== 1'b1) begin
      n_fail++; $display("FAIL x0_discard: en=%b lg=%0d, required en=0 lg=1", rf_en, last_grant);
    end
  endtask

  task automatic test_back_to_back();
    logic [N_REQ-1:0] exp_rdy;
    set_req(0, 1'b1, 5'd10, 32'hA0A0_0000);
    set_req(1, 1'b1, 5'd11, 32'hB1B1_0001);
    for (int c = 0; c < 4; c++) begin
      exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_tests++;
      if (req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b, required %b", c, req_ready, exp_rdy);
      end
      tick();
      n_tests++;
      if (rf_en !== 1'b1 || conflict !== 1'b1 || write_addr !== ((c % 2 == 0) ? 5'd10 : 5'd11)) begin
        n_fail++;
        $display("FAIL rr_write[%0d]: en=%b conflict=%b addr=%0d", c, rf_en, conflict, write_addr);
      end
    end
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
  endtask

  task automatic test_stall();
    set_req(0, 1'b1, 5'd20, 32'h2020_2020);
    set_req(1, 1'b1, 5'd21, 32'h2121_2121);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (req_ready !== '0) begin
        n_fail++; $display("FAIL stall_ready[%0d]: got %b, required 00", c, req_ready);
      end
      tick();
      n_tests++;
      if (rf_en !== 1'b0 || conflict !== 1'b0) begin
        n_fail++; $display("FAIL stall_out[%0d]: en=%b conflict=%b, required 0/0", c, rf_en, conflict);
      end
    end
    stall = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL stall_release: got %b, required 01", req_ready);
    end
    tick();
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    n_tests++;
    if (rf_en !== 1'b1 || write_addr !== 5'd20) begin
      n_fail++; $display("FAIL stall_write: en=%b addr=%0d, required 1/20", rf_en, write_addr);
    end
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b1, 5'd7, 32'h7777_7777);
    tick();
    set_req(0, 1'b0, '0, '0);
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (rf_en !== 1'b0 || last_grant !== '0) begin
      n_fail++; $display("FAIL rst_async: en=%b lg=%0d, required 0/0", rf_en, last_grant);
    end
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (rf_en !== 1'b0) begin
      n_fail++; $display("FAIL rst_lost_write: en=%b addr=%0d, required en=0", rf_en, write_addr);
    end
    set_req(0, 1'b1, 5'd12, 32'h1200_0012);
    set_req(1, 1'b1, 5'd13, 32'h1300_0013);
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL rst_ptr: got %b, required 01", req_ready);
    end
    tick();
    set_req(0, 1'b0, '0, '0);
    tick();
    set_req(1, 1'b0, '0, '0);
  endtask

  task automatic test_lsu_stream();
    for (int a = 1; a <= 3; a++) begin
      set_req(1, 1'b1, ADDR_W'(a), 32'hC0DE_0000 + a);
      #1;
      n_tests++;
      if (req_ready !== 2'b10) begin
        n_fail++; $display("FAIL lsu_ready[%0d]: got %b, required 10", a, req_ready);
      end
      tick();
      n_tests++;
      if (rf_en !== 1'b1 || write_addr !== ADDR_W'(a) || last_grant !== 1'b1) begin
        n_fail++;
        $display("FAIL lsu_write[%0d]: en=%b addr=%0d lg=%0d, required 1/%0d/1", a, rf_en, write_addr, last_grant, a);
      end
    end
    set_req(1, 1'b0, '0, '0);
    tick();
    n_tests++;
    if (rf_en !== 1'b0 || write_addr !== 5'd3) begin
      n_fail++; $display("FAIL lsu_idle: en=%b addr=%0d, required 0/3", rf_en, write_addr);
    end
  endtask

  initial begin
    fork
      scoreboard();
    join_none
    test_reset();
    test_single();
    test_x0_write();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_lsu_stream();
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
